nes_cpu: RTL and testbench
==========================

NES_CPU -- requirements
Module: nes_cpu

Interface
REQ-001 clk_ph1  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset; synchronous, active-low.
REQ-003 clk_ph2  in  1  complementary phase input, kept for pin compatibility; ignored by all logic.
REQ-004 Data_bus  in  8  read data, combinationally valid for the current Addr_bus.
REQ-005 Addr_bus  out  16  read address; registered.
REQ-006 IR_dbg  out  8  instruction register.
REQ-007 AC_dbg  out  8  accumulator A.
REQ-008 PC_dbg  out  16  program counter.
REQ-009 cycle_dbg  out  3  cycle index within the current instruction (0 = opcode fetch).

Function
REQ-010 Read-only bus, no write strobe; 6502-subset, binary arithmetic only (no D flag); flags C, Z, N, V.
REQ-011 Opcodes:
- ADC 69/65/6D, SBC E9/E5/ED, AND 29/25/2D, ORA 09/05/0D, EOR 49/45/4D, LDA A9/A5/AD, CMP C9/C5/CD (IMM/ZPG/ABS).
- Implied: CLC 18, SEC 38, CLV B8, NOP EA.
REQ-012 Any other opcode, including 00, is a 1-byte, 2-cycle NOP.
REQ-013 Cycle 0: Addr_bus=PC; IR<=Data_bus; PC<=PC+1.
REQ-014 IMM, 2 cycles: cycle 1 Addr_bus=PC, operand=Data_bus, execute, PC+1.
REQ-015 ZPG, 3 cycles: cycle 1 latch zero-page address from Data_bus, PC+1; cycle 2 Addr_bus={8'h00,addr}, operand=Data_bus, execute.
REQ-016 ABS, 4 cycles: cycles 1-2 latch low then high address byte, PC+1 each; cycle 3 Addr_bus={hi,lo}, operand, execute.
REQ-017 Implied, 2 cycles: cycle 1 dummy read at PC (PC not incremented), execute.
REQ-018 Execute writes A and flags on the last cycle's edge; next instruction's cycle 0 follows immediately.
REQ-019 ADC: {C,A}=A+M+C; V=(A7==M7)&&(R7!=A7).
REQ-020 SBC: ADC with ~M; C=1 means no borrow.
REQ-021 CMP: R=A-M, C=(A>=M), N/Z from R, A unchanged.
REQ-022 AND/ORA/EOR/LDA update N,Z only.
REQ-023 N=R[7], Z=(R==0) on all ALU ops.
REQ-024 PC wraps FFFF->0000.

Reset
REQ-025 While rst=0 at an edge: PC=0000, A=00, IR=00 (NOP), C=Z=N=V=0, cycle=0, Addr_bus=0000.
REQ-026 First fetch at 0000 on the first edge after rst=1; no reset vector.
REQ-027 Reset mid-instruction abandons it without updating A or flags.

Configuration
REQ-028 Macro NES_CPU_ABS_EN.
- Defined: ABS opcodes (6D, ED, 2D, 0D, 4D, AD, CD) execute per REQ-016.
- Undefined: they decode as 1-byte, 2-cycle NOPs per REQ-012 and no ABS logic is built.

Structure
REQ-029 Package nes_cpu_pkg: opcode localparams, ALU-op enum (ADD, SUB, AND, OR, XOR, PASS, CMP), addressing-mode enum (IMP, IMM, ZPG, ABS).
REQ-030 Sub-module nes_cpu_alu: combinational; inputs A, M, C_in, op; outputs R, C, V, N, Z.
REQ-031 Top level holds the decoder, cycle counter and registers.

Verification
REQ-032 Program at 0000: 69 04 65 07 38 E9 09 05 (mem[7]=05) -> A=04 after ADC imm, 09 after ADC zpg (Addr_bus=0007 in its cycle 2), 00 after SBC #09 with C=1, Z=1; cycle_dbg sequences 0-1, 0-1-2, 0-1, 0-1.
REQ-033 Program 69 50 69 50 -> A=A0, V=1, N=1, C=0; appending 69 00 gives A=A0.
REQ-034 Program 18 69 FF 69 02 -> A=FF, then A=01 with C=1.
REQ-035 With NES_CPU_ABS_EN: AD 34 12 (mem[1234]=7F) -> Addr_bus=1234 in cycle 3, A=7F, PC_dbg=0003.
REQ-036 rst low during cycle 1 of 69 04 -> A=00, PC=0000, cycle_dbg=0; all-zero memory -> PC advances by 1 every 2 cycles.

Source files
------------

// File: rtl/nes_cpu_pkg.sv
// Shared opcodes, ALU/addressing enums and the instruction decoder for nes_cpu.
// Absolute-mode opcodes decode as NOPs unless NES_CPU_ABS_EN is defined.
package nes_cpu_pkg;

    localparam logic [7:0] OpAdcImm = 8'h69;
    localparam logic [7:0] OpAdcZpg = 8'h65;
    localparam logic [7:0] OpAdcAbs = 8'h6D;
    localparam logic [7:0] OpSbcImm = 8'hE9;
    localparam logic [7:0] OpSbcZpg = 8'hE5;
    localparam logic [7:0] OpSbcAbs = 8'hED;
    localparam logic [7:0] OpAndImm = 8'h29;
    localparam logic [7:0] OpAndZpg = 8'h25;
    localparam logic [7:0] OpAndAbs = 8'h2D;
    localparam logic [7:0] OpOraImm = 8'h09;
    localparam logic [7:0] OpOraZpg = 8'h05;
    localparam logic [7:0] OpOraAbs = 8'h0D;
    localparam logic [7:0] OpEorImm = 8'h49;
    localparam logic [7:0] OpEorZpg = 8'h45;
    localparam logic [7:0] OpEorAbs = 8'h4D;
    localparam logic [7:0] OpLdaImm = 8'hA9;
    localparam logic [7:0] OpLdaZpg = 8'hA5;
    localparam logic [7:0] OpLdaAbs = 8'hAD;
    localparam logic [7:0] OpCmpImm = 8'hC9;
    localparam logic [7:0] OpCmpZpg = 8'hC5;
    localparam logic [7:0] OpCmpAbs = 8'hCD;
    localparam logic [7:0] OpClc    = 8'h18;
    localparam logic [7:0] OpSec    = 8'h38;
    localparam logic [7:0] OpClv    = 8'hB8;
    localparam logic [7:0] OpNop    = 8'hEA;

    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluPass, AluCmp
    } alu_op_e;

    typedef enum logic [1:0] {
        ModeImp, ModeImm, ModeZpg, ModeAbs
    } addr_mode_e;

    typedef enum logic [1:0] {
        ImpNop, ImpClc, ImpSec, ImpClv
    } imp_op_e;

    typedef struct packed {
        addr_mode_e mode;
        logic       alu_en;
        alu_op_e    alu_op;
        imp_op_e    imp_op;
    } decode_t;

    function automatic decode_t decode(input logic [7:0] opcode);
        decode_t d;
        d.mode   = ModeImp;
        d.alu_en = 1'b0;
        d.alu_op = AluPass;
        d.imp_op = ImpNop;
        case (opcode)
            OpAdcImm, OpSbcImm, OpAndImm, OpOraImm, OpEorImm, OpLdaImm, OpCmpImm: begin
                d.mode   = ModeImm;
                d.alu_en = 1'b1;
            end
            OpAdcZpg, OpSbcZpg, OpAndZpg, OpOraZpg, OpEorZpg, OpLdaZpg, OpCmpZpg: begin
                d.mode   = ModeZpg;
                d.alu_en = 1'b1;
            end
            OpAdcAbs, OpSbcAbs, OpAndAbs, OpOraAbs, OpEorAbs, OpLdaAbs, OpCmpAbs: begin
                d.mode   = ModeAbs;
                d.alu_en = 1'b1;
            end
            OpClc:   d.imp_op = ImpClc;
            OpSec:   d.imp_op = ImpSec;
            OpClv:   d.imp_op = ImpClv;
            OpNop:   d.imp_op = ImpNop;
            default: d.imp_op = ImpNop;
        endcase
        if (d.alu_en) begin
            case (opcode[7:4])
                4'h6:    d.alu_op = AluAdd;
                4'hE:    d.alu_op = AluSub;
                4'h2:    d.alu_op = AluAnd;
                4'h0:    d.alu_op = AluOr;
                4'h4:    d.alu_op = AluXor;
                4'hC:    d.alu_op = AluCmp;
                default: d.alu_op = AluPass;
            endcase
        end
`ifndef NES_CPU_ABS_EN
        // Without the absolute-mode datapath these are plain 2-cycle NOPs.
        if (d.mode == ModeAbs) begin
            d.mode   = ModeImp;
            d.alu_en = 1'b0;
        end
`endif
        return d;
    endfunction

endpackage

// File: rtl/nes_cpu_alu.sv
// Combinational ALU for nes_cpu: add/subtract with carry, logic ops, load-pass and compare.
module nes_cpu_alu
    import nes_cpu_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] m_i,
    input  logic       c_i,
    input  alu_op_e    op_i,
    output logic [7:0] r_o,
    output logic       c_o,
    output logic       v_o,
    output logic       n_o,
    output logic       z_o
);

    logic [7:0] m_eff;
    logic       carry_in;
    logic [8:0] sum;

    always_comb begin
        // SBC and CMP reuse the adder on the inverted operand; CMP forces carry-in.
        m_eff    = (op_i == AluSub || op_i == AluCmp) ? ~m_i : m_i;
        carry_in = (op_i == AluCmp) ? 1'b1 : c_i;
        sum      = {1'b0, a_i} + {1'b0, m_eff} + {8'h00, carry_in};
        r_o      = sum[7:0];
        c_o      = c_i;
        v_o      = 1'b0;
        case (op_i)
            AluAdd, AluSub, AluCmp: begin
                r_o = sum[7:0];
                c_o = sum[8];
                v_o = (a_i[7] == m_eff[7]) && (sum[7] != a_i[7]);
            end
            AluAnd:  r_o = a_i & m_i;
            AluOr:   r_o = a_i | m_i;
            AluXor:  r_o = a_i ^ m_i;
            AluPass: r_o = m_i;
            default: r_o = m_i;
        endcase
        n_o = r_o[7];
        z_o = (r_o == 8'h00);
    end

endmodule

// File: rtl/nes_cpu.sv
// nes_cpu top: read-only 6502-subset core with decoder, cycle counter and architectural state.
// Absolute addressing is built only when NES_CPU_ABS_EN is defined.
module nes_cpu
    import nes_cpu_pkg::*;
(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic        clk_ph2,
    input  logic [7:0]  Data_bus,
    output logic [15:0] Addr_bus,
    output logic [7:0]  IR_dbg,
    output logic [7:0]  AC_dbg,
    output logic [15:0] PC_dbg,
    output logic [2:0]  cycle_dbg
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  ir_q, ir_d;
    logic [2:0]  cyc_q, cyc_d;
    logic        c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
`ifdef NES_CPU_ABS_EN
    logic [7:0]  lo_q, lo_d;
`endif

    logic        exec;
    decode_t     dec;
    logic [7:0]  alu_r;
    logic        alu_c, alu_v, alu_n, alu_z;

    // Second phase exists only for pin compatibility.
    logic unused_clk_ph2;
    assign unused_clk_ph2 = clk_ph2;

    nes_cpu_alu u_alu (
        .a_i  (a_q),
        .m_i  (Data_bus),
        .c_i  (c_q),
        .op_i (dec.alu_op),
        .r_o  (alu_r),
        .c_o  (alu_c),
        .v_o  (alu_v),
        .n_o  (alu_n),
        .z_o  (alu_z)
    );

    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        a_d    = a_q;
        ir_d   = ir_q;
        cyc_d  = cyc_q;
        c_d    = c_q;
        z_d    = z_q;
        n_d    = n_q;
        v_d    = v_q;
`ifdef NES_CPU_ABS_EN
        lo_d   = lo_q;
`endif
        exec   = 1'b0;
        dec    = decode(ir_q);

        case (cyc_q)
            3'd0: begin
                ir_d   = Data_bus;
                pc_d   = pc_q + 16'd1;
                addr_d = pc_q + 16'd1;
                cyc_d  = 3'd1;
            end
            3'd1: begin
                case (dec.mode)
                    ModeImm: begin
                        exec   = 1'b1;
                        pc_d   = pc_q + 16'd1;
                        addr_d = pc_q + 16'd1;
                        cyc_d  = 3'd0;
                    end
                    ModeZpg: begin
                        pc_d   = pc_q + 16'd1;
                        addr_d = {8'h00, Data_bus};
                        cyc_d  = 3'd2;
                    end
`ifdef NES_CPU_ABS_EN
                    ModeAbs: begin
                        lo_d   = Data_bus;
                        pc_d   = pc_q + 16'd1;
                        addr_d = pc_q + 16'd1;
                        cyc_d  = 3'd2;
                    end
`endif
                    default: begin
                        // Implied: the dummy read at PC does not advance PC.
                        exec   = 1'b1;
                        addr_d = pc_q;
                        cyc_d  = 3'd0;
                    end
                endcase
            end
            3'd2: begin
`ifdef NES_CPU_ABS_EN
                if (dec.mode == ModeAbs) begin
                    pc_d   = pc_q + 16'd1;
                    addr_d = {Data_bus, lo_q};
                    cyc_d  = 3'd3;
                end else begin
                    exec   = 1'b1;
                    addr_d = pc_q;
                    cyc_d  = 3'd0;
                end
`else
                exec   = 1'b1;
                addr_d = pc_q;
                cyc_d  = 3'd0;
`endif
            end
`ifdef NES_CPU_ABS_EN
            3'd3: begin
                exec   = 1'b1;
                addr_d = pc_q;
                cyc_d  = 3'd0;
            end
`endif
            default: begin
                addr_d = pc_q;
                cyc_d  = 3'd0;
            end
        endcase

        if (exec) begin
            if (dec.alu_en) begin
                if (dec.alu_op != AluCmp) begin
                    a_d = alu_r;
                end
                n_d = alu_n;
                z_d = alu_z;
                if (dec.alu_op == AluAdd || dec.alu_op == AluSub || dec.alu_op == AluCmp) begin
                    c_d = alu_c;
                end
                if (dec.alu_op == AluAdd || dec.alu_op == AluSub) begin
                    v_d = alu_v;
                end
            end else begin
                case (dec.imp_op)
                    ImpClc:  c_d = 1'b0;
                    ImpSec:  c_d = 1'b1;
                    ImpClv:  v_d = 1'b0;
                    default: c_d = c_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            pc_q   <= 16'h0000;
            addr_q <= 16'h0000;
            a_q    <= 8'h00;
            ir_q   <= 8'h00;
            cyc_q  <= 3'd0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
`ifdef NES_CPU_ABS_EN
            lo_q   <= 8'h00;
`endif
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            a_q    <= a_d;
            ir_q   <= ir_d;
            cyc_q  <= cyc_d;
            c_q    <= c_d;
            z_q    <= z_d;
            n_q    <= n_d;
            v_q    <= v_d;
`ifdef NES_CPU_ABS_EN
            lo_q   <= lo_d;
`endif
        end
    end

    assign Addr_bus  = addr_q;
    assign IR_dbg    = ir_q;
    assign AC_dbg    = a_q;
    assign PC_dbg    = pc_q;
    assign cycle_dbg = cyc_q;

endmodule

// File: tb/tb_nes_cpu.sv
// Self-checking bench for nes_cpu: directed programs plus random programs against an
// instruction-level reference model.
module tb_nes_cpu;

    logic        clk_ph1 = 1'b0;
    logic        clk_ph2;
    logic        rst;
    logic [7:0]  Data_bus;
    logic [15:0] Addr_bus;
    logic [7:0]  IR_dbg;
    logic [7:0]  AC_dbg;
    logic [15:0] PC_dbg;
    logic [2:0]  cycle_dbg;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

`ifdef NES_CPU_ABS_EN
    localparam bit AbsEn = 1'b1;
`else
    localparam bit AbsEn = 1'b0;
`endif

    // Reference model state
    logic [15:0] m_pc;
    logic [7:0]  m_a;
    logic [7:0]  m_ir;
    bit          m_c, m_z, m_n, m_v;

    logic [7:0] ops [0:31] = '{
        8'h69, 8'h65, 8'h6D, 8'hE9, 8'hE5, 8'hED, 8'h29, 8'h25,
        8'h2D, 8'h09, 8'h05, 8'h0D, 8'h49, 8'h45, 8'h4D, 8'hA9,
        8'hA5, 8'hAD, 8'hC9, 8'hC5, 8'hCD, 8'h18, 8'h38, 8'hB8,
        8'hEA, 8'h00, 8'hFF, 8'h02, 8'h13, 8'h8A, 8'hF0, 8'hD8
    };

    always #5 clk_ph1 = ~clk_ph1;
    assign clk_ph2  = ~clk_ph1;
    assign Data_bus = mem[Addr_bus];

    nes_cpu dut (
        .clk_ph1   (clk_ph1),
        .rst       (rst),
        .clk_ph2   (clk_ph2),
        .Data_bus  (Data_bus),
        .Addr_bus  (Addr_bus),
        .IR_dbg    (IR_dbg),
        .AC_dbg    (AC_dbg),
        .PC_dbg    (PC_dbg),
        .cycle_dbg (cycle_dbg)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ph1);
        @(negedge clk_ph1);
    endtask

    // 0 implied/NOP, 1 immediate, 2 zero page, 3 absolute
    function automatic int mode_of(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = op[7:4];
        lo = op[3:0];
        if (!(hi inside {4'h0, 4'h2, 4'h4, 4'h6, 4'hA, 4'hC, 4'hE})) return 0;
        if (lo == 4'h9) return 1;
        if (lo == 4'h5) return 2;
        if (lo == 4'hD) return AbsEn ? 3 : 0;
        return 0;
    endfunction

    function automatic int len_of(input int mode);
        return (mode == 0) ? 1 : (mode == 3) ? 3 : 2;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        m_pc = 16'h0000;
        m_a  = 8'h00;
        m_ir = 8'h00;
        m_c  = 0;
        m_z  = 0;
        m_n  = 0;
        m_v  = 0;
        check("rst_pc", PC_dbg, 16'h0000);
        check("rst_a", 16'(AC_dbg), 16'h0000);
        check("rst_ir", 16'(IR_dbg), 16'h0000);
        check("rst_cyc", 16'(cycle_dbg), 16'h0000);
        check("rst_addr", Addr_bus, 16'h0000);
        rst = 1'b1;
    endtask

    // Run one instruction on the DUT and the model, comparing bus and state.
    task automatic run_instr(input string tag);
        logic [7:0]  op, b1, b2, m;
        logic [15:0] p1, p2, ea, npc;
        logic [15:0] addrs[$];
        int          mode, a, mm, sum, r;
        op   = mem[m_pc];
        p1   = m_pc + 16'd1;
        p2   = m_pc + 16'd2;
        b1   = mem[p1];
        b2   = mem[p2];
        mode = mode_of(op);
        m    = 8'h00;
        addrs = {m_pc, p1};
        npc  = m_pc + 16'(len_of(mode));
        if (mode == 1) m = b1;
        if (mode == 2) begin
            ea = {8'h00, b1};
            addrs.push_back(ea);
            m = mem[ea];
        end
        if (mode == 3) begin
            ea = {b2, b1};
            addrs.push_back(p2);
            addrs.push_back(ea);
            m = mem[ea];
        end
        for (int k = 0; k < addrs.size(); k++) begin
            if (k > 0) tick();
            check({tag, ".cyc"}, 16'(cycle_dbg), 16'(k));
            check({tag, ".addr"}, Addr_bus, addrs[k]);
        end
        tick();

        a  = int'(m_a);
        mm = int'(m);
        r  = a;
        if (mode == 0) begin
            if (op == 8'h18) m_c = 0;
            if (op == 8'h38) m_c = 1;
            if (op == 8'hB8) m_v = 0;
        end else begin
            case (op[7:4])
                4'h6, 4'hE: begin
                    if (op[7:4] == 4'hE) mm = 255 - mm;
                    sum = a + mm + (m_c ? 1 : 0);
                    r   = sum % 256;
                    m_v = (((a ^ mm) & 128) == 0) && (((a ^ r) & 128) != 0);
                    m_c = sum > 255;
                end
                4'hC: begin
                    r   = (a - mm + 256) % 256;
                    m_c = a >= mm;
                end
                4'h2:    r = a & mm;
                4'h0:    r = a | mm;
                4'h4:    r = a ^ mm;
                default: r = mm;
            endcase
            m_n = r >= 128;
            m_z = r == 0;
            if (op[7:4] != 4'hC) m_a = 8'(r);
        end
        m_pc = npc;
        m_ir = op;

        check({tag, ".a"}, 16'(AC_dbg), 16'(m_a));
        check({tag, ".pc"}, PC_dbg, m_pc);
        check({tag, ".ir"}, 16'(IR_dbg), 16'(m_ir));
        check({tag, ".cyc0"}, 16'(cycle_dbg), 16'h0000);
    endtask

    task automatic load_prog(input logic [7:0] prog[$]);
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    initial begin
        logic [7:0] prog[$];
        int         pos;
        int         mode;
        logic [7:0] op;

        rst = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // ADC imm, ADC zpg, SEC, SBC imm
        prog = {8'h69, 8'h04, 8'h65, 8'h07, 8'h38, 8'hE9, 8'h09, 8'h05};
        load_prog(prog);
        do_reset();
        run_instr("p1_adc_imm");
        check("p1_a1", 16'(AC_dbg), 16'h0004);
        run_instr("p1_adc_zpg");
        check("p1_a2", 16'(AC_dbg), 16'h0009);
        run_instr("p1_sec");
        run_instr("p1_sbc");
        check("p1_a4", 16'(AC_dbg), 16'h0000);

        // Signed overflow
        prog = {8'h69, 8'h50, 8'h69, 8'h50, 8'h69, 8'h00};
        load_prog(prog);
        do_reset();
        run_instr("p2_i1");
        run_instr("p2_i2");
        check("p2_a2", 16'(AC_dbg), 16'h00A0);
        run_instr("p2_i3");
        check("p2_a3", 16'(AC_dbg), 16'h00A0);

        // Carry out then carry in
        prog = {8'h18, 8'h69, 8'hFF, 8'h69, 8'h02, 8'h69, 8'h00};
        load_prog(prog);
        do_reset();
        run_instr("p3_clc");
        run_instr("p3_i2");
        check("p3_a2", 16'(AC_dbg), 16'h00FF);
        run_instr("p3_i3");
        check("p3_a3", 16'(AC_dbg), 16'h0001);
        run_instr("p3_i4");
        check("p3_a4", 16'(AC_dbg), 16'h0002);

        // Absolute load (or 2-cycle NOP without the ABS build)
        prog = {8'hAD, 8'h34, 8'h12};
        load_prog(prog);
        mem[16'h1234] = 8'h7F;
        do_reset();
        run_instr("p4_lda_abs");
`ifdef NES_CPU_ABS_EN
        check("p4_a", 16'(AC_dbg), 16'h007F);
        check("p4_pc", PC_dbg, 16'h0003);
`else
        check("p4_a", 16'(AC_dbg), 16'h0000);
        check("p4_pc", PC_dbg, 16'h0001);
`endif

        // Reset in cycle 1 abandons the instruction
        prog = {8'h69, 8'h04};
        load_prog(prog);
        do_reset();
        tick();
        check("p5_cyc1", 16'(cycle_dbg), 16'h0001);
        rst = 1'b0;
        tick();
        check("p5_a", 16'(AC_dbg), 16'h0000);
        check("p5_pc", PC_dbg, 16'h0000);
        check("p5_cyc", 16'(cycle_dbg), 16'h0000);

        // All-zero memory: every BRK slot is a 2-cycle NOP
        prog = {};
        load_prog(prog);
        do_reset();
        for (int i = 0; i < 6; i++) run_instr("p6_nop");
        check("p6_pc", PC_dbg, 16'h0006);

        // Random programs
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
            pos = 0;
            for (int i = 0; i < 40; i++) begin
                op = ops[$urandom_range(0, 31)];
                mem[pos] = op;
                mode = mode_of(op);
                pos += len_of(mode);
            end
            do_reset();
            for (int i = 0; i < 40; i++) run_instr("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
